// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - Single-outstanding memory bus master arbitrating fetch and load-store ports
// Optional WAIT timeout enabled by defining MEM_MASTER_TIMEOUT_EN.
module mem_bus_master #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ready,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req_valid,
    output logic              mem_we,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              mem_data_valid
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_tmo_range
        $error("TIMEOUT_CYC must be within 1..255");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                src_ls_q, src_ls_d;
    logic                if_done_q, if_done_d;
    logic                ls_done_q, ls_done_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                complete;
    logic                timed_out;
`ifdef MEM_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]          tmo_q, tmo_d;
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        wdata_d    = wdata_q;
        src_ls_d   = src_ls_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        complete   = 1'b0;
        timed_out  = 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Load-store always wins; fetch only issues when LSU is quiet.
                if (ls_req) begin
                    mem_addr_d = ls_addr;
                    mem_we_d   = ls_we;
                    wdata_d    = ls_wdata;
                    src_ls_d   = 1'b1;
                    state_d    = S_ISSUE;
                end else if (if_req) begin
                    mem_addr_d = if_addr;
                    mem_we_d   = 1'b0;
                    src_ls_d   = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef MEM_MASTER_TIMEOUT_EN
                tmo_d   = 8'd0;
`endif
            end
            S_WAIT: begin
                if (mem_data_valid) begin
                    complete = 1'b1;
                    state_d  = S_DONE;
                end
`ifdef MEM_MASTER_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (complete) begin
            if (src_ls_q) begin
                ls_done_d = 1'b1;
                if (timed_out)      ls_rdata_d = '0;
                else if (!mem_we_q) ls_rdata_d = mem_data;
            end else begin
                if_done_d = 1'b1;
                if (timed_out)      if_rdata_d = '0;
                else                if_rdata_d = mem_data;
            end
`ifdef MEM_MASTER_TIMEOUT_EN
            err_d = timed_out;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            wdata_q    <= '0;
            src_ls_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_MASTER_TIMEOUT_EN
            tmo_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            wdata_q    <= wdata_d;
            src_ls_q   <= src_ls_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_MASTER_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign ls_ready      = (state_q == S_IDLE);
    assign if_ready      = (state_q == S_IDLE) && !ls_req;
    assign mem_req_valid = (state_q == S_ISSUE);
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign if_done       = if_done_q;
    assign ls_done       = ls_done_q;
    assign if_rdata      = if_rdata_q;
    assign ls_rdata      = ls_rdata_q;
`ifdef MEM_MASTER_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

    // The bus is only ours while a write is in flight; reads leave it to the memory.
    assign mem_data = (mem_we_q && (state_q == S_ISSUE || state_q == S_WAIT)) ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - Directed self-checking bench for mem_bus_master
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_ready, if_done;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0, ls_we = 1'b0;
    logic [7:0]  ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ready, ls_done;
    logic [31:0] ls_rdata;
    logic        err;
    logic [7:0]  mem_addr;
    logic        mem_req_valid, mem_we;
    wire  [31:0] mem_data;
    logic        mem_data_valid = 1'b0;

    logic [31:0] mem [256];
    logic        drv = 1'b0;
    logic [31:0] drv_data = '0;
    logic        pend = 1'b0;
    logic [7:0]  p_addr = '0;
    logic        p_we = 1'b0;
    int          wait_cnt = 0;
    int          lat = 0;

    int n_checks = 0;
    int n_pass   = 0;

    assign mem_data = drv ? drv_data : 'z;

    mem_bus_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ready(ls_ready), .ls_done(ls_done), .ls_rdata(ls_rdata), .err(err),
        .mem_addr(mem_addr), .mem_req_valid(mem_req_valid), .mem_we(mem_we),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    // Memory model: answers `lat` WAIT cycles after seeing the request.
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0; mem_data_valid = 1'b0; drv = 1'b0;
        end else if (mem_req_valid) begin
            pend = 1'b1; p_addr = mem_addr; p_we = mem_we; wait_cnt = 0;
            mem_data_valid = 1'b0; drv = 1'b0;
        end else if (pend) begin
            if (wait_cnt == lat) begin
                if (p_we) mem[p_addr] = mem_data;
                else begin drv = 1'b1; drv_data = mem[p_addr]; end
                mem_data_valid = 1'b1;
                pend = 1'b0;
            end else begin
                wait_cnt++;
            end
        end else begin
            mem_data_valid = 1'b0; drv = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic access(input bit is_ls, input bit we, input logic [7:0] addr,
                          input logic [31:0] wdata, output int cyc, output int nreq,
                          output int vcyc, output bit saw_err, output logic [31:0] bus_seen);
        @(negedge clk);
        if (is_ls) begin ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; end
        else begin if_req = 1'b1; if_addr = addr; end
        @(posedge clk); #1;
        ls_req = 1'b0; if_req = 1'b0;
        cyc = 0; nreq = 0; vcyc = 0; saw_err = 1'b0; bus_seen = '0;
        while (cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (mem_req_valid) begin nreq++; bus_seen = mem_data; end
            if (mem_data_valid && vcyc == 0) vcyc = cyc;
            if (err) saw_err = 1'b1;
            if (is_ls ? ls_done : if_done) break;
        end
    endtask

    int          cyc, nreq, vcyc, ls_at, if_at;
    bit          saw_err;
    logic [31:0] bus;

    initial begin
        foreach (mem[i]) mem[i] = 32'h0;
        mem[0] = 32'h00A00313;
        mem[3] = 32'h00100E93;
        mem[5] = 32'h0BADF00D;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr",  {24'b0, mem_addr}, 32'd0);
        check("rst_if_done",   {31'b0, if_done}, 32'd0);
        check("rst_ls_done",   {31'b0, ls_done}, 32'd0);
        check("rst_err",       {31'b0, err}, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_ls_rdata",  ls_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ls_ready", {31'b0, ls_ready}, 32'd1);
        check("idle_if_ready", {31'b0, if_ready}, 32'd1);

        // Fetch of word 3
        access(1'b0, 1'b0, 8'd3, 32'h0, cyc, nreq, vcyc, saw_err, bus);
        check("fetch_latency", cyc, 32'd3);
        check("fetch_req_cycles", nreq, 32'd1);
        check("fetch_rdata", if_rdata, 32'h00100E93);
        check("fetch_addr_hold", {24'b0, mem_addr}, 32'd3);
        check("fetch_no_err", {31'b0, saw_err}, 32'd0);

        // Write 0xDEADBEEF to 10, then read it back
        access(1'b1, 1'b1, 8'd10, 32'hDEADBEEF, cyc, nreq, vcyc, saw_err, bus);
        check("wr_latency", cyc, 32'd3);
        check("wr_bus_data", bus, 32'hDEADBEEF);
        check("wr_mem_content", mem[10], 32'hDEADBEEF);
        check("wr_rdata_kept", ls_rdata, 32'd0);
        check("wr_we_hold", {31'b0, mem_we}, 32'd1);
        access(1'b1, 1'b0, 8'd10, 32'h0, cyc, nreq, vcyc, saw_err, bus);
        check("rd_back", ls_rdata, 32'hDEADBEEF);
        check("rd_we_low", {31'b0, mem_we}, 32'd0);

        // Simultaneous fetch(0) and load(5): LSU first
        @(negedge clk);
        if_req = 1'b1; if_addr = 8'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'd5;
        #1;
        check("arb_if_ready_low", {31'b0, if_ready}, 32'd0);
        @(posedge clk); #1;
        ls_req = 1'b0;
        ls_at = 0; if_at = 0; cyc = 0;
        while (cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (ls_done && ls_at == 0) begin
                ls_at = cyc;
                check("arb_ls_rdata", ls_rdata, 32'h0BADF00D);
            end
            if (if_done) begin
                if_at = cyc;
                check("arb_if_rdata", if_rdata, 32'h00A00313);
                break;
            end
            if (if_req && if_ready) begin @(posedge clk); #1; if_req = 1'b0; end
        end
        if_req = 1'b0;
        check("arb_ls_done_cyc", ls_at, 32'd3);
        check("arb_if_done_cyc", if_at, 32'd7);

`ifdef MEM_MASTER_TIMEOUT_EN
        lat = 1000;
        access(1'b1, 1'b0, 8'd5, 32'h0, cyc, nreq, vcyc, saw_err, bus);
        check("tmo_done_cyc", cyc, 32'd17);
        check("tmo_err", {31'b0, err}, 32'd1);
        check("tmo_rdata_zero", ls_rdata, 32'd0);
        lat = 0;
`else
        lat = 40;
        access(1'b1, 1'b0, 8'd3, 32'h0, cyc, nreq, vcyc, saw_err, bus);
        check("slow_done_cyc", cyc, 32'd43);
        check("slow_done_after_valid", cyc - vcyc, 32'd1);
        check("slow_no_err", {31'b0, saw_err}, 32'd0);
        check("slow_rdata", ls_rdata, 32'h00100E93);
        lat = 0;
`endif

        // Reset in the middle of WAIT
        lat = 100;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'd5;
        @(posedge clk); #1;
        ls_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_wait_idle", {31'b0, ls_ready}, 32'd1);
        check("rst_wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_wait_no_done", {31'b0, ls_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        access(1'b1, 1'b0, 8'd5, 32'h0, cyc, nreq, vcyc, saw_err, bus);
        check("post_rst_latency", cyc, 32'd3);
        check("post_rst_rdata", ls_rdata, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
